// File: rtl/wasm_fetch_buffer.sv
// rtl/wasm_fetch_buffer.sv - byte-granular instruction fetch queue feeding a WASM decoder
// Fetches aligned words, realigns them into a circular byte queue and presents a 16-byte window.
module wasm_fetch_buffer #(
  parameter int DEPTH           = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        consume_valid,
  input  logic [7:0]  consume_len,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [7:0]  instr_bytes [16],
  output logic [3:0]  bytes_available
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [7:0]    qmem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] out_next;
  logic [7:0]    skip_rem;
  logic [1:0]    align_skip;
  logic [31:0]   fetch_addr;
  logic          post_reset;

  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          consume_ok;
  logic [31:0]   fill_level;
  logic [3:0]    skip_total;
  logic [2:0]    discard;
  logic [2:0]    kept_eff;
  logic [31:0]   total_bytes;

  // Reserve queue room for every word still in flight before issuing another.
  assign fill_level    = 32'(count) + (32'(outstanding) << 2) + 32'd4;
  assign mem_req_valid = !rst && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         && (fill_level <= 32'(DEPTH));
  assign mem_req_addr  = fetch_addr;

  assign req_fire   = mem_req_valid && mem_req_ready;
  assign rsp_fire   = mem_rsp_valid && !post_reset;
  assign rsp_keep   = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign consume_ok = consume_valid && valid_out;
  assign out_next   = outstanding + OW'(req_fire) - OW'(rsp_fire);

  // Leading bytes of a word are discarded first for alignment, then for a pending long skip.
  always_comb begin
    skip_total  = {2'b00, align_skip} + ((skip_rem > 8'd4) ? 4'd4 : skip_rem[3:0]);
    discard     = (skip_total > 4'd4) ? 3'd4 : skip_total[2:0];
    kept_eff    = rsp_keep ? (3'd4 - discard) : 3'd0;
    total_bytes = 32'(count) + 32'(kept_eff);
  end

  assign valid_out       = (count >= CW'(16)) && (drop_cnt == '0) && (skip_rem == 8'd0);
  assign bytes_available = (count >= CW'(15)) ? 4'd15 : count[3:0];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      instr_bytes[i] = qmem[head + PW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rsp_keep) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) >= discard) begin
          qmem[tail + PW'(j) - PW'(discard)] <= mem_rsp_data[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      skip_rem    <= 8'd0;
      align_skip  <= 2'b00;
      pc_out      <= 32'd0;
      fetch_addr  <= 32'd0;
      post_reset  <= 1'b1;
    end else begin
      post_reset  <= 1'b0;
      outstanding <= out_next;
      if (redirect_valid) begin
        head       <= tail;
        count      <= '0;
        pc_out     <= redirect_pc;
        fetch_addr <= {redirect_pc[31:2], 2'b00};
        align_skip <= redirect_pc[1:0];
        skip_rem   <= 8'd0;
        drop_cnt   <= out_next;
      end else begin
        if (req_fire) begin
          fetch_addr <= fetch_addr + 32'd4;
        end
        if (rsp_fire) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - OW'(1);
          end else begin
            align_skip <= 2'b00;
            skip_rem   <= skip_rem - 8'(discard - {1'b0, align_skip});
          end
        end
        tail <= tail + PW'(kept_eff);
        // Consume sees the bytes of a same-cycle response, so a long skip also eats them.
        if (consume_ok) begin
          pc_out <= pc_out + 32'(consume_len);
          if (32'(consume_len) <= total_bytes) begin
            head  <= head + PW'(consume_len);
            count <= CW'(total_bytes - 32'(consume_len));
          end else begin
            head     <= tail + PW'(kept_eff);
            count    <= '0;
            skip_rem <= 8'(32'(consume_len) - total_bytes);
          end
        end else begin
          count <= count + CW'(kept_eff);
        end
      end
    end
  end
endmodule

// File: tb/tb_wasm_fetch_buffer.sv
// tb/tb_wasm_fetch_buffer.sv - self-checking bench for wasm_fetch_buffer
// Models the fetched instruction stream as a byte queue anchored at the expected PC.
module tb_wasm_fetch_buffer;
  localparam int DEPTH = 32;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        consume_valid;
  logic [7:0]  consume_len;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [7:0]  instr_bytes [16];
  logic [3:0]  bytes_available;

  wasm_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .valid_out(valid_out), .pc_out(pc_out), .instr_bytes(instr_bytes),
    .bytes_available(bytes_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rsp_pct = 100;
  int rdy_pct = 100;
  bit spurious = 1'b0;

  // Reference state: bytes from exp_pc onward, next stream byte owed, expected fetch address.
  logic [7:0]  mq [$];
  logic [31:0] pend_addr [$];
  logic        pend_stale [$];
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] next_byte = 32'd0;
  logic [31:0] exp_fetch = 32'd0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic logic model_valid();
    logic stale_any = 1'b0;
    foreach (pend_stale[i]) if (pend_stale[i]) stale_any = 1'b1;
    return (mq.size() >= 16) && (next_byte == exp_pc + 32'(mq.size())) && !stale_any;
  endfunction

  function automatic int model_avail();
    return (mq.size() > 15) ? 15 : mq.size();
  endfunction

  // One clock: drive memory side, check request channel, advance the reference model.
  task automatic step();
    logic        rsp;
    logic        acc;
    logic        stale_f;
    logic        pre_valid;
    logic        exp_req;
    logic [31:0] a;
    logic [31:0] acc_addr;
    rsp = (pend_addr.size() > 0) && (int'($urandom_range(99)) < rsp_pct);
    mem_rsp_valid = rsp || spurious;
    mem_rsp_data  = rsp ? word_at(pend_addr[0]) : $urandom();
    mem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    pre_valid = model_valid();
    #1;
    exp_req = (pend_addr.size() < MAXO) && (mq.size() + 4 * pend_addr.size() + 4 <= DEPTH);
    checks++;
    if (mem_req_valid !== exp_req) begin
      errors++;
      $display("FAIL req_valid: got %b expected %b t=%0t", mem_req_valid, exp_req, $time);
    end
    if (mem_req_valid === 1'b1) begin
      checks++;
      if (mem_req_addr !== exp_fetch) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h t=%0t", mem_req_addr, exp_fetch, $time);
      end
    end
    acc = (mem_req_valid === 1'b1) && mem_req_ready;
    acc_addr = mem_req_addr;
    @(posedge clk);
    a = 32'd0;
    stale_f = 1'b0;
    if (rsp) begin
      a = pend_addr.pop_front();
      stale_f = pend_stale.pop_front();
    end
    if (acc) begin
      pend_addr.push_back(acc_addr);
      pend_stale.push_back(1'b0);
      exp_fetch += 32'd4;
    end
    if (redirect_valid) begin
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      mq.delete();
      exp_pc    = redirect_pc;
      next_byte = redirect_pc;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end else begin
      if (rsp && !stale_f) begin
        for (int k = 0; k < 4; k++) begin
          if (a + 32'(k) == next_byte) begin
            mq.push_back(mem_byte(next_byte));
            next_byte += 32'd1;
          end
        end
      end
      if (consume_valid && pre_valid) begin
        exp_pc += 32'(consume_len);
        if (int'(consume_len) <= mq.size()) begin
          for (int k = 0; k < int'(consume_len); k++) void'(mq.pop_front());
        end else begin
          mq.delete();
          next_byte = exp_pc;
        end
      end
    end
    @(negedge clk);
    spurious = 1'b0;
    redirect_valid = 1'b0;
    consume_valid = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_valid); end
    checks++; if (bytes_available !== 4'd0) begin errors++; $display("FAIL reset_avail: got %0d expected 0", bytes_available); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
    rst = 1'b0;
    spurious = 1'b1;
    step();
    checks++; if (bytes_available !== 4'd0) begin errors++; $display("FAIL spurious_rsp: got %0d expected 0", bytes_available); end
  endtask

  task automatic test_cold_start();
    int n = 0;
    while (valid_out !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL cold_valid: got %b expected 1 within 20 cycles", valid_out); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL cold_pc: got %h expected 0", pc_out); end
    checks++; if (instr_bytes[0] !== 8'h00) begin errors++; $display("FAIL cold_b0: got %h expected 00", instr_bytes[0]); end
    checks++; if (instr_bytes[15] !== 8'h0F) begin errors++; $display("FAIL cold_b15: got %h expected 0f", instr_bytes[15]); end
    checks++; if (bytes_available !== 4'd15) begin errors++; $display("FAIL cold_avail: got %0d expected 15", bytes_available); end
  endtask

  task automatic test_consume();
    consume_valid = 1'b1;
    consume_len = 8'd3;
    step();
    checks++; if (pc_out !== 32'd3) begin errors++; $display("FAIL consume_pc: got %h expected 3", pc_out); end
    checks++; if (instr_bytes[0] !== 8'h03) begin errors++; $display("FAIL consume_b0: got %h expected 03", instr_bytes[0]); end
    checks++; if (valid_out !== model_valid()) begin errors++; $display("FAIL consume_valid: got %b expected %b", valid_out, model_valid()); end
    checks++; if (bytes_available !== 4'(model_avail())) begin errors++; $display("FAIL consume_avail: got %0d expected %0d", bytes_available, model_avail()); end
    for (int i = 0; i < 16 && i < mq.size(); i++) begin
      checks++;
      if (instr_bytes[i] !== mem_byte(32'(3 + i))) begin
        errors++; $display("FAIL consume_lane%0d: got %h expected %h", i, instr_bytes[i], mem_byte(32'(3 + i)));
      end
    end
  endtask

  task automatic test_unaligned_redirect();
    int n = 0;
    rsp_pct = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    while (pend_addr.size() < 2 && n < 10) begin step(); n++; end
    checks++; if (pend_addr.size() != 2) begin errors++; $display("FAIL unal_setup: got %0d outstanding expected 2", pend_addr.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    rsp_pct = 100;
    n = 0;
    while (valid_out !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL unal_valid: got %b expected 1 within 30 cycles", valid_out); end
    checks++; if (n < 5) begin errors++; $display("FAIL unal_latency: got %0d cycles expected at least 5", n); end
    checks++; if (pc_out !== 32'h102) begin errors++; $display("FAIL unal_pc: got %h expected 102", pc_out); end
    checks++; if (instr_bytes[0] !== mem_byte(32'h102)) begin errors++; $display("FAIL unal_b0: got %h expected %h", instr_bytes[0], mem_byte(32'h102)); end
    checks++; if (instr_bytes[15] !== mem_byte(32'h111)) begin errors++; $display("FAIL unal_b15: got %h expected %h", instr_bytes[15], mem_byte(32'h111)); end
  endtask

  task automatic test_long_skip();
    int n = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    while (valid_out !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL skip_setup: got %b expected 1", valid_out); end
    rsp_pct = 0;
    consume_valid = 1'b1; consume_len = 8'd40;
    step();
    checks++; if (pc_out !== 32'd40) begin errors++; $display("FAIL skip_pc: got %h expected 28", pc_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skip_valid: got %b expected 0", valid_out); end
    checks++; if (bytes_available !== 4'd0) begin errors++; $display("FAIL skip_avail: got %0d expected 0", bytes_available); end
    rsp_pct = 100;
    n = 0;
    while (valid_out !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL skip_refill: got %b expected 1 within 40 cycles", valid_out); end
    checks++; if (pc_out !== 32'd40) begin errors++; $display("FAIL skip_pc2: got %h expected 28", pc_out); end
    checks++; if (instr_bytes[0] !== mem_byte(32'd40)) begin errors++; $display("FAIL skip_b0: got %h expected %h", instr_bytes[0], mem_byte(32'd40)); end
    checks++; if (instr_bytes[15] !== mem_byte(32'd55)) begin errors++; $display("FAIL skip_b15: got %h expected %h", instr_bytes[15], mem_byte(32'd55)); end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    while (pend_addr.size() == 0 && n < 10) begin
      consume_valid = 1'b1; consume_len = 8'd8;
      step(); n++;
    end
    checks++; if (pend_addr.size() == 0) begin errors++; $display("FAIL simul_setup: got 0 outstanding expected nonzero"); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    consume_valid = 1'b1; consume_len = 8'd2;
    step();
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL simul_pc: got %h expected 200", pc_out); end
    checks++; if (bytes_available !== 4'd0) begin errors++; $display("FAIL simul_avail: got %0d expected 0", bytes_available); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL simul_valid: got %b expected 0", valid_out); end
    consume_valid = 1'b1; consume_len = 8'd5;
    step();
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL illegal_consume: got %h expected 200", pc_out); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    rdy_pct = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    for (int c = 0; c < 10; c++) begin
      checks++; if (mem_req_addr !== 32'h300) begin errors++; $display("FAIL bp_addr: got %h expected 300", mem_req_addr); end
      step();
    end
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_req: got %b expected 1", mem_req_valid); end
    rdy_pct = 100;
    while (valid_out !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", valid_out); end
    checks++; if (instr_bytes[0] !== mem_byte(32'h300)) begin errors++; $display("FAIL bp_b0: got %h expected %h", instr_bytes[0], mem_byte(32'h300)); end
    checks++; if (instr_bytes[15] !== mem_byte(32'h30F)) begin errors++; $display("FAIL bp_b15: got %h expected %h", instr_bytes[15], mem_byte(32'h30F)); end
  endtask

  task automatic test_wrap();
    int n = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF6;
    step();
    while (valid_out !== 1'b1 && n < 30) begin step(); n++; end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", valid_out); end
    checks++; if (pc_out !== 32'hFFFF_FFF6) begin errors++; $display("FAIL wrap_pc: got %h expected fffffff6", pc_out); end
    checks++; if (instr_bytes[0] !== mem_byte(32'hFFFF_FFF6)) begin errors++; $display("FAIL wrap_b0: got %h expected %h", instr_bytes[0], mem_byte(32'hFFFF_FFF6)); end
    checks++; if (instr_bytes[15] !== mem_byte(32'h5)) begin errors++; $display("FAIL wrap_b15: got %h expected %h", instr_bytes[15], mem_byte(32'h5)); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      if (c % 32 == 0) begin
        rsp_pct = int'($urandom_range(100, 25));
        rdy_pct = int'($urandom_range(100, 25));
      end
      r = int'($urandom_range(99));
      if (r < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(1023));
      end
      if (r >= 2 && r < 55) begin
        consume_valid = 1'b1;
        consume_len = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 1)) : 8'($urandom_range(12, 1));
      end
      step();
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL rnd_pc: got %h expected %h t=%0t", pc_out, exp_pc, $time); end
      checks++; if (valid_out !== model_valid()) begin errors++; $display("FAIL rnd_valid: got %b expected %b t=%0t", valid_out, model_valid(), $time); end
      checks++; if (bytes_available !== 4'(model_avail())) begin errors++; $display("FAIL rnd_avail: got %0d expected %0d t=%0t", bytes_available, model_avail(), $time); end
      for (int i = 0; i < 16 && i < mq.size(); i++) begin
        checks++;
        if (instr_bytes[i] !== mq[i]) begin
          errors++; $display("FAIL rnd_lane%0d: got %h expected %h t=%0t", i, instr_bytes[i], mq[i], $time);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    consume_valid = 1'b0;
    consume_len = 8'd0;
    test_reset();
    test_cold_start();
    test_consume();
    test_unaligned_redirect();
    test_long_skip();
    test_simultaneous();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit t=%0t", $time);
    $fatal(1);
  end
endmodule
